// File: rtl/sci2_rx.sv
// SCI2 receive decoder: oversamples the line clock/data, deframes 13-bit words
// and assembles one command word plus up to four info words into a single report.
module sci2_rx #(
    parameter bit          PARITY_ODD   = 1'b1,
    parameter int unsigned MAX_WORDS    = 5,
    parameter int unsigned RESYNC_BITS  = 13,
    parameter int unsigned SCI2_W_ADDR  = 5,
    parameter int unsigned SCI2_W_GROUP = 1,
    parameter int unsigned SCI2_W_CMD   = 3,
    parameter int unsigned SCI2_W_DATA  = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sci_clk,
    input  logic                       sci_data,
    input  logic [SCI2_W_ADDR-1:0]     my_addr,
    output logic                       cmd_valid,
    output logic [SCI2_W_ADDR-1:0]     cmd_addr,
    output logic [SCI2_W_GROUP-1:0]    cmd_group,
    output logic [SCI2_W_CMD-1:0]      cmd_code,
    output logic [4*SCI2_W_DATA-1:0]   info_data,
    output logic [2:0]                 cmd_words,
    output logic                       cmd_match,
    output logic                       err_parity,
    output logic                       err_stop,
    output logic                       err_mark,
    output logic                       err_len
);

    localparam logic [SCI2_W_GROUP-1:0] SCI2_GROUP_NO  = '0;
    localparam logic                    SCI2_MARK_CMD  = 1'b1;
    localparam logic                    SCI2_MARK_INFO = 1'b0;
    localparam int                      W              = SCI2_W_DATA;
    localparam logic [2:0]              MAX_W3         = 3'(MAX_WORDS);
    localparam int                      RS_W           = $clog2(RESYNC_BITS + 1);
    localparam logic [RS_W-1:0]         RS_LAST        = RS_W'(RESYNC_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WORD,
        S_GAP,
        S_DONE,
        S_RESYNC
    } state_t;

    function automatic logic f_parity_ok(input logic [11:1] bits);
        return (^bits) == PARITY_ODD;
    endfunction

    logic                     r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic                     r_sdat_meta, r_sdat_sync;
    logic                     r_bit_stb, r_bit_dat;

    state_t                   r_state;
    logic [3:0]               r_bit_idx;
    logic [2:0]               r_word_cnt;
    logic [11:1]              r_shift;
    logic [RS_W-1:0]          r_rs_cnt;
    logic                     r_after_err;

    logic [SCI2_W_ADDR-1:0]   r_acc_addr;
    logic [SCI2_W_GROUP-1:0]  r_acc_group;
    logic [SCI2_W_CMD-1:0]    r_acc_code;
    logic [4*W-1:0]           r_acc_info;
    logic                     r_acc_par, r_acc_stop, r_acc_mark, r_acc_len;

    logic                     r_cmd_valid;
    logic [SCI2_W_ADDR-1:0]   r_cmd_addr;
    logic [SCI2_W_GROUP-1:0]  r_cmd_group;
    logic [SCI2_W_CMD-1:0]    r_cmd_code;
    logic [4*W-1:0]           r_info_data;
    logic [2:0]               r_cmd_words;
    logic                     r_cmd_match;
    logic                     r_err_parity, r_err_stop, r_err_mark, r_err_len;

    logic [12:1]              w_word;
    logic [W-1:0]             w_data;
    logic                     w_mark_exp;

    // Synchronize the asynchronous line and derive the mid-bit sample strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_sdat_meta <= 1'b1;
            r_sdat_sync <= 1'b1;
            r_bit_stb   <= 1'b0;
            r_bit_dat   <= 1'b1;
        end else begin
            r_sclk_meta <= sci_clk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_sdat_meta <= sci_data;
            r_sdat_sync <= r_sdat_meta;
            r_bit_stb   <= r_sclk_sync & ~r_sclk_prev;
            r_bit_dat   <= r_sdat_sync;
        end
    end

    // Complete word as seen when its stop bit is being sampled.
    always_comb begin
        w_word     = {r_bit_dat, r_shift};
        w_data     = w_word[W:1];
        w_mark_exp = (r_word_cnt == 3'd0) ? SCI2_MARK_CMD : SCI2_MARK_INFO;
    end

    // Receive FSM with command accumulators and the registered command report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bit_idx    <= 4'd0;
            r_word_cnt   <= 3'd0;
            r_shift      <= '0;
            r_rs_cnt     <= '0;
            r_after_err  <= 1'b0;
            r_acc_addr   <= '0;
            r_acc_group  <= '0;
            r_acc_code   <= '0;
            r_acc_info   <= '0;
            r_acc_par    <= 1'b0;
            r_acc_stop   <= 1'b0;
            r_acc_mark   <= 1'b0;
            r_acc_len    <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_group  <= '0;
            r_cmd_code   <= '0;
            r_info_data  <= '0;
            r_cmd_words  <= 3'd0;
            r_cmd_match  <= 1'b0;
            r_err_parity <= 1'b0;
            r_err_stop   <= 1'b0;
            r_err_mark   <= 1'b0;
            r_err_len    <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_bit_stb && !r_bit_dat) begin
                        r_state     <= S_WORD;
                        r_bit_idx   <= 4'd1;
                        r_word_cnt  <= 3'd0;
                        r_after_err <= 1'b0;
                        r_acc_info  <= '0;
                        r_acc_par   <= 1'b0;
                        r_acc_stop  <= 1'b0;
                        r_acc_mark  <= 1'b0;
                        r_acc_len   <= 1'b0;
                    end
                end
                S_WORD: begin
                    if (r_bit_stb) begin
                        if (r_bit_idx == 4'd12) begin
                            case (r_word_cnt)
                                3'd0: begin
                                    r_acc_addr  <= w_data[SCI2_W_ADDR-1:0];
                                    r_acc_group <= w_data[SCI2_W_ADDR +: SCI2_W_GROUP];
                                    r_acc_code  <= w_data[SCI2_W_ADDR+SCI2_W_GROUP +: SCI2_W_CMD];
                                end
                                3'd1:    r_acc_info[0*W +: W] <= w_data;
                                3'd2:    r_acc_info[1*W +: W] <= w_data;
                                3'd3:    r_acc_info[2*W +: W] <= w_data;
                                3'd4:    r_acc_info[3*W +: W] <= w_data;
                                default: r_acc_info <= r_acc_info;
                            endcase
                            r_word_cnt <= r_word_cnt + 3'd1;
                            if (!f_parity_ok(w_word[11:1])) r_acc_par  <= 1'b1;
                            if (w_word[10] != w_mark_exp)   r_acc_mark <= 1'b1;
                            // A broken stop bit means framing is lost: report now, then resync.
                            if (!w_word[12]) begin
                                r_acc_stop  <= 1'b1;
                                r_after_err <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_shift[r_bit_idx] <= r_bit_dat;
                            r_bit_idx          <= r_bit_idx + 4'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_bit_stb) begin
                        if (!r_bit_dat) begin
                            if (r_word_cnt == MAX_W3) begin
                                r_acc_len   <= 1'b1;
                                r_after_err <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_state   <= S_WORD;
                                r_bit_idx <= 4'd1;
                            end
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_cmd_valid  <= 1'b1;
                    r_cmd_addr   <= r_acc_addr;
                    r_cmd_group  <= r_acc_group;
                    r_cmd_code   <= r_acc_code;
                    r_info_data  <= r_acc_info;
                    r_cmd_words  <= r_word_cnt;
                    r_cmd_match  <= (r_acc_addr == my_addr) || (r_acc_group != SCI2_GROUP_NO);
                    r_err_parity <= r_acc_par;
                    r_err_stop   <= r_acc_stop;
                    r_err_mark   <= r_acc_mark;
                    r_err_len    <= r_acc_len;
                    r_rs_cnt     <= '0;
                    r_state      <= r_after_err ? S_RESYNC : S_IDLE;
                end
                S_RESYNC: begin
                    if (r_bit_stb) begin
                        if (!r_bit_dat) begin
                            r_rs_cnt <= '0;
                        end else if (r_rs_cnt == RS_LAST) begin
                            r_rs_cnt <= '0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_rs_cnt <= r_rs_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd_addr   = r_cmd_addr;
    assign cmd_group  = r_cmd_group;
    assign cmd_code   = r_cmd_code;
    assign info_data  = r_info_data;
    assign cmd_words  = r_cmd_words;
    assign cmd_match  = r_cmd_match;
    assign err_parity = r_err_parity;
    assign err_stop   = r_err_stop;
    assign err_mark   = r_err_mark;
    assign err_len    = r_err_len;

endmodule
